// File: rtl/reflet_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with fixed read latency.
// One access in flight at a time: IDLE (arbitrate) -> ACCESS (ram_latency cycles) -> DONE (pulse).
module reflet_ram_arbiter #(
  parameter int wordsize    = 16,
  parameter int ram_latency = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic [wordsize-1:0] addr0,
  input  logic [wordsize-1:0] wdata0,
  input  logic                we0,
  output logic [wordsize-1:0] rdata0,
  output logic                done0,
  input  logic                req1,
  input  logic [wordsize-1:0] addr1,
  input  logic [wordsize-1:0] wdata1,
  input  logic                we1,
  output logic [wordsize-1:0] rdata1,
  output logic                done1,
  output logic                grant,
  output logic                busy,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_data_out,
  input  logic [wordsize-1:0] ram_data_in,
  output logic                ram_write_en
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = (ram_latency > 1) ? $clog2(ram_latency) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ram_latency - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic                last_q, last_d;
  logic                grant_q, grant_d;
  logic                wr_q, wr_d;
  logic                we_q, we_d;
  logic [wordsize-1:0] addr_q, addr_d;
  logic [wordsize-1:0] wdat_q, wdat_d;
  logic [wordsize-1:0] rdata0_q, rdata0_d;
  logic [wordsize-1:0] rdata1_q, rdata1_d;
  logic                start, pick;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    start = req0 | req1;
    pick  = (req0 & req1) ? ~last_q : req1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCESS;
      ACCESS:  if (count_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    last_d   = last_q;
    grant_d  = grant_q;
    wr_d     = wr_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = pick ? addr1  : addr0;
        wdat_d  = pick ? wdata1 : wdata0;
        wr_d    = pick ? we1    : we0;
        we_d    = pick ? we1    : we0;
        grant_d = pick;
        last_d  = pick;
        count_d = CNT_INIT;
      end
      ACCESS: begin
        if (count_q != '0) count_d = count_q - CW'(1);
        else if (!wr_q) begin
          if (grant_q) rdata1_d = ram_data_in;
          else         rdata0_d = ram_data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      wr_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      count_q  <= count_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // The write strobe flop is only ever set on the grant edge, so it covers the first ACCESS cycle.
  always_comb begin
    done0        = (state_q == DONE) & ~grant_q;
    done1        = (state_q == DONE) &  grant_q;
    busy         = (state_q != IDLE);
    grant        = grant_q;
    ram_addr     = addr_q;
    ram_data_out = wdat_q;
    ram_write_en = we_q;
    rdata0       = rdata0_q;
    rdata1       = rdata1_q;
  end
endmodule

// File: tb/tb_reflet_ram_arbiter.sv
// Directed bench: three arbiters (ram_latency 1, 2, 4) share stimulus; sel picks the active one.
module tb_reflet_ram_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         req0, we0, req1, we1;
  logic [W-1:0] addr0, wdata0, addr1, wdata1;
  logic [1:0]   sel;
  int           lat;

  logic [W-1:0] rd0_a [3], rd1_a [3], ra_a [3], rdo_a [3];
  logic         dn0_a [3], dn1_a [3], gr_a [3], bz_a [3], we_a [3];
  logic [W-1:0] rdin;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    reflet_ram_arbiter #(.wordsize(W), .ram_latency(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0 && sel == 2'(g)), .addr0(addr0), .wdata0(wdata0), .we0(we0),
      .rdata0(rd0_a[g]), .done0(dn0_a[g]),
      .req1(req1 && sel == 2'(g)), .addr1(addr1), .wdata1(wdata1), .we1(we1),
      .rdata1(rd1_a[g]), .done1(dn1_a[g]),
      .grant(gr_a[g]), .busy(bz_a[g]),
      .ram_addr(ra_a[g]), .ram_data_out(rdo_a[g]), .ram_data_in(rdin),
      .ram_write_en(we_a[g])
    );
  end

  logic [W-1:0] m_rd0, m_rd1, m_addr, m_dout;
  logic         m_done0, m_done1, m_grant, m_busy, m_we;
  always_comb begin
    m_rd0 = rd0_a[sel]; m_rd1 = rd1_a[sel]; m_addr = ra_a[sel]; m_dout = rdo_a[sel];
    m_done0 = dn0_a[sel]; m_done1 = dn1_a[sel]; m_grant = gr_a[sel];
    m_busy = bz_a[sel]; m_we = we_a[sel];
  end

  // RAM model: read data trails the address by ram_latency-1 register stages.
  logic [W-1:0] mem [256];
  logic [W-1:0] p1, p2, p3;
  logic         tb_we;
  logic [7:0]   tb_wa;
  logic [W-1:0] tb_wd;
  always @(posedge clk) begin
    if (m_we)       mem[m_addr[7:0]] <= m_dout;
    else if (tb_we) mem[tb_wa] <= tb_wd;
    p1 <= m_addr; p2 <= p1; p3 <= p2;
  end
  always_comb begin
    case (sel)
      2'd0:    rdin = mem[m_addr[7:0]];
      2'd1:    rdin = mem[p1[7:0]];
      default: rdin = mem[p3[7:0]];
    endcase
  end

  int vecs = 0, errs = 0;
  logic [W-1:0] last_wa, last_wd;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_sel(input logic [1:0] s);
    sel = s;
    lat = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endtask

  task automatic poke(input logic [7:0] a, input logic [W-1:0] d);
    tb_wa = a; tb_wd = d; tb_we = 1'b1;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20 && m_busy; n++) tick();
  endtask

  // Raise one request and run until its done; cyc counts edges from request to done (-1 on timeout).
  task automatic run_txn(input bit p, input bit w, input logic [W-1:0] a, input logic [W-1:0] wd,
                         output int cyc, output logic [W-1:0] rd, output int wes, output int odone);
    cyc = -1; wes = 0; odone = 0; rd = '0;
    wait_idle();
    if (!p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd; end
    else    begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = wd; end
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (m_we) begin wes++; last_wa = m_addr; last_wd = m_dout; end
      if (p ? m_done0 : m_done1) odone++;
      if (p ? m_done1 : m_done0) begin cyc = n; rd = p ? m_rd1 : m_rd0; break; end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) begin
      vecs++;
      if ({rd0_a[g], rd1_a[g], ra_a[g], rdo_a[g], dn0_a[g], dn1_a[g], gr_a[g], bz_a[g], we_a[g]} !== '0) begin
        errs++;
        $display("FAIL reset_outputs dut%0d: got addr=%h dout=%h rd0=%h rd1=%h d0=%b d1=%b g=%b b=%b we=%b, want all 0",
                 g, ra_a[g], rdo_a[g], rd0_a[g], rd1_a[g], dn0_a[g], dn1_a[g], gr_a[g], bz_a[g], we_a[g]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    int cyc, wes, od; logic [W-1:0] rd;
    poke(8'h10, 16'hBEEF);
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, cyc, rd, wes, od);
    vecs++;
    if (cyc !== lat + 1) begin errs++; $display("FAIL read_latency L=%0d: got %0d, want %0d", lat, cyc, lat + 1); end
    vecs++;
    if (rd !== 16'hBEEF) begin errs++; $display("FAIL read_data L=%0d: got %h, want beef", lat, rd); end
    vecs++;
    if (od !== 0 || wes !== 0) begin errs++; $display("FAIL read_side L=%0d: done1=%0d strobes=%0d, want 0/0", lat, od, wes); end
    tick();
    vecs++;
    if (m_done0 !== 1'b0) begin errs++; $display("FAIL read_pulse L=%0d: done0=%b after pulse, want 0", lat, m_done0); end
  endtask

  task automatic test_single_write();
    int cyc, wes, od; logic [W-1:0] rd;
    run_txn(1'b1, 1'b1, 16'h0004, 16'h1234, cyc, rd, wes, od);
    vecs++;
    if (wes !== 1 || last_wa !== 16'h0004 || last_wd !== 16'h1234) begin
      errs++; $display("FAIL write_strobe L=%0d: strobes=%0d addr=%h data=%h, want 1/0004/1234", lat, wes, last_wa, last_wd);
    end
    vecs++;
    if (cyc !== lat + 1) begin errs++; $display("FAIL write_latency L=%0d: got %0d, want %0d", lat, cyc, lat + 1); end
    run_txn(1'b0, 1'b0, 16'h0004, 16'h0000, cyc, rd, wes, od);
    vecs++;
    if (rd !== 16'h1234) begin errs++; $display("FAIL write_readback L=%0d: got %h, want 1234", lat, rd); end
  endtask

  task automatic test_contention();
    int ports [4], edges [4], k;
    logic [W-1:0] data [4];
    logic [W-1:0] v0, v1;
    v0 = 16'hA0A0 ^ 16'(lat); v1 = 16'h5151 ^ 16'(lat);
    poke(8'h20, v0); poke(8'h21, v1);
    do_reset();
    k = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0021;
    for (int n = 1; n <= 4 * (lat + 2) + 4 && k < 4; n++) begin
      tick();
      if (m_done0 || m_done1) begin
        ports[k] = m_done1 ? 1 : 0; edges[k] = n; data[k] = m_done1 ? m_rd1 : m_rd0; k++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    vecs++;
    if (k !== 4) begin errs++; $display("FAIL contention_count L=%0d: got %0d dones, want 4", lat, k); end
    for (int i = 0; i < k; i++) begin
      vecs++;
      if (ports[i] !== (i % 2) || edges[i] !== (lat + 1) + i * (lat + 2) || data[i] !== ((i % 2) ? v1 : v0)) begin
        errs++;
        $display("FAIL contention_%0d L=%0d: port=%0d edge=%0d data=%h, want port=%0d edge=%0d data=%h",
                 i, lat, ports[i], edges[i], data[i], i % 2, (lat + 1) + i * (lat + 2), (i % 2) ? v1 : v0);
      end
    end
    wait_idle();
  endtask

  task automatic test_mid_change();
    int dones = 0, wes = 0;
    poke(8'h30, 16'h0000); poke(8'hFF, 16'h0000);
    wait_idle();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h5A5A;
    tick();
    addr0 = 16'h00FF; wdata0 = 16'hFFFF; req0 = 1'b0;
    if (m_we) wes++;
    for (int n = 0; n < lat + 4; n++) begin
      tick();
      if (m_done0) dones++;
      if (m_we) wes++;
    end
    vecs++;
    if (dones !== 1 || wes !== 1) begin errs++; $display("FAIL mid_change_pulses: done0=%0d strobes=%0d, want 1/1", dones, wes); end
    vecs++;
    if (mem[8'h30] !== 16'h5A5A || mem[8'hFF] !== 16'h0000) begin
      errs++; $display("FAIL mid_change_data: mem30=%h memFF=%h, want 5a5a/0000", mem[8'h30], mem[8'hFF]);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    wait_idle();
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
    tick();
    req1 = 1'b0;
    vecs++;
    if (m_busy !== 1'b1 || m_grant !== 1'b1) begin errs++; $display("FAIL reset_mid_setup: busy=%b grant=%b, want 1/1", m_busy, m_grant); end
    reset = 1'b1;
    #1;
    vecs++;
    if ({m_rd0, m_rd1, m_addr, m_dout, m_done0, m_done1, m_grant, m_busy, m_we} !== '0) begin
      errs++; $display("FAIL reset_mid_outputs: addr=%h rd1=%h busy=%b grant=%b done1=%b, want all 0", m_addr, m_rd1, m_busy, m_grant, m_done1);
    end
    tick();
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (m_done1 || m_busy) stray++;
    end
    vecs++;
    if (stray !== 0) begin errs++; $display("FAIL reset_mid_stray: %0d cycles busy/done1 after release, want 0", stray); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0004;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    vecs++;
    if (m_busy !== 1'b1 || m_grant !== 1'b0) begin errs++; $display("FAIL reset_mid_tie: busy=%b grant=%b, want 1/0", m_busy, m_grant); end
    wait_idle();
  endtask

  initial begin
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0; last_wa = '0; last_wd = '0;
    set_sel(2'd1);
    #2;
    test_reset();
    for (int s = 0; s < 3; s++) begin
      set_sel(2'(s));
      do_reset();
      test_single_read();
      test_single_write();
      test_contention();
    end
    set_sel(2'd1);
    test_mid_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
